// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// In-flight entries are held in a fixed-width record so the type can live in the package.
package fwd_pkg;

    localparam int unsigned FWD_RF = 0;

    // Widest supported register address; narrower AW values are zero-extended into rd.
    localparam int unsigned RD_MAXW = 8;

    typedef struct packed {
        logic               valid;
        logic [RD_MAXW-1:0] rd;
        logic               is_load;
    } inflight_entry_t;

    function automatic int unsigned sel_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search of one source operand against the in-flight entries.
// The lowest (youngest) matching stage wins.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned AW          = 4,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned IDXW        = 1,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  inflight_entry_t [STAGES-1:0] entries,
    input  logic                         idValid,
    input  logic                         srcUsed,
    input  logic [AW-1:0]                src,
    output logic                         hit,
    output logic [IDXW-1:0]              stageIdx,
    output logic                         isLoadHit
);

    logic srcZero;
    logic srcLive;

    assign srcZero = ZERO_REG_EN && (src == '0);
    assign srcLive = idValid && srcUsed && !srcZero;

    // Walk from oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit       = 1'b0;
        stageIdx  = '0;
        isLoadHit = 1'b0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (srcLive && entries[k].valid && (entries[k].rd == RD_MAXW'(src))) begin
                hit       = 1'b1;
                stageIdx  = IDXW'(k);
                isLoadHit = entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall for the decode stage, with an in-flight write
// tracker (stage 0 = youngest) and a saturating stall-cycle counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned AW          = 4,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned NSRC        = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter bit          ZERO_REG_EN = 1'b1,
    parameter int unsigned CNTW        = 16,
    localparam int unsigned SELW       = sel_width(STAGES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_regwrite,
    input  logic                 id_is_load,
    input  logic                 flush,
    output logic                 stall_out,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic [CNTW-1:0]      stall_cnt
);

    localparam int unsigned IDXW = (STAGES > 1) ? $clog2(STAGES) : 1;

    inflight_entry_t [STAGES-1:0] entryQ;
    inflight_entry_t [STAGES-1:0] entryD;
    inflight_entry_t              newEntry;

    logic [NSRC-1:0]            hit;
    logic [NSRC-1:0]            loadHit;
    logic [NSRC-1:0]            hazard;
    logic [NSRC-1:0][IDXW-1:0]  stageIdx;
    logic [CNTW-1:0]            stallCntQ;

    for (genvar i = 0; i < NSRC; i++) begin : gSrc
        fwd_match #(
            .AW          (AW),
            .STAGES      (STAGES),
            .IDXW        (IDXW),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) uMatch (
            .entries   (entryQ),
            .idValid   (id_valid),
            .srcUsed   (id_src_used[i]),
            .src       (id_src[i*AW +: AW]),
            .hit       (hit[i]),
            .stageIdx  (stageIdx[i]),
            .isLoadHit (loadHit[i])
        );

        // Load data is not yet available in stages younger than LOAD_LAT.
        assign hazard[i] = hit[i] && loadHit[i] && (32'(stageIdx[i]) < LOAD_LAT);
    end

    assign stall_out = |hazard;

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            fwd_sel[i*SELW +: SELW] = SELW'(FWD_RF);
            if (!stall_out && hit[i]) begin
                fwd_sel[i*SELW +: SELW] = SELW'(stageIdx[i]) + SELW'(1);
            end
        end
    end

    // Non-writing and stalled instructions still take a slot so stage indices track the pipe.
    always_comb begin
        newEntry.valid   = id_valid && id_regwrite && !stall_out;
        newEntry.rd      = RD_MAXW'(id_rd);
        newEntry.is_load = id_is_load;

        entryD    = '0;
        entryD[0] = newEntry;
        for (int k = 1; k < int'(STAGES); k++) begin
            entryD[k] = entryQ[k-1];
        end
        if (flush) begin
            entryD = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entryQ <= '0;
        end else begin
            entryQ <= entryD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntQ <= '0;
        end else if (stall_out && !flush && (stallCntQ != {CNTW{1'b1}})) begin
            stallCntQ <= stallCntQ + CNTW'(1);
        end
    end

    assign stall_cnt = stallCntQ;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed test of fwd_hazard_unit with default parameters (AW=4, STAGES=2, NSRC=2).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_src;
    logic [1:0]  id_src_used;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_is_load;
    logic        flush;
    logic        stall_out;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit uDut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .stall_out   (stall_out),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one decode-stage instruction, then let combinational outputs settle.
    task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic [3:0] rd, input logic rw,
                         input logic ld, input logic fl);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        #10;
        checkVal("rst_stall", 32'(stall_out), 0);
        checkVal("rst_sel", 32'(fwd_sel), 0);
        checkVal("rst_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;

        // 1. plain ALU forwarding from stage 0 then stage 1
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd12, 4'd15, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t1_sel0", 32'(fwd_sel[1:0]), 1);
        checkVal("t1_sel1", 32'(fwd_sel[3:2]), 0);
        checkVal("t1_stall", 32'(stall_out), 0);
        tick();
        drive(1'b1, 4'd15, 4'd12, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t1_sel1_st1", 32'(fwd_sel[3:2]), 2);
        checkVal("t1_sel0_none", 32'(fwd_sel[1:0]), 0);
        tick();

        // 2. youngest producer wins
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd13, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd13, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd13, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t2_youngest", 32'(fwd_sel[1:0]), 1);
        tick();

        // 3. load-use: one stall cycle, then forward from stage 1
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0, 1'b0);
        checkVal("t3_stall", 32'(stall_out), 1);
        checkVal("t3_sel_forced", 32'(fwd_sel), 0);
        checkVal("t3_cnt_before", 32'(stall_cnt), 0);
        tick();
        checkVal("t3_cnt_after", 32'(stall_cnt), 1);
        checkVal("t3_stall_clear", 32'(stall_out), 0);
        checkVal("t3_sel_st1", 32'(fwd_sel[1:0]), 2);
        tick();
        drive(1'b1, 4'd5, 4'd12, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t3_bubble_sel0", 32'(fwd_sel[1:0]), 1);
        checkVal("t3_bubble_sel1", 32'(fwd_sel[3:2]), 0);
        checkVal("t3_cnt_hold", 32'(stall_cnt), 1);
        tick();

        // 4. filters: zero register, unused operand, non-writing producer
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t4_zero_reg", 32'(fwd_sel), 0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd11, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd11, 4'd11, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t4_unused_stall", 32'(stall_out), 0);
        checkVal("t4_unused_sel", 32'(fwd_sel), 0);
        tick();
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t4_no_regwrite", 32'(fwd_sel), 0);
        tick();

        // 5. flush squashes an issuing load, and a stall under flush is not counted
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t5_stall", 32'(stall_out), 0);
        checkVal("t5_sel", 32'(fwd_sel[1:0]), 0);
        checkVal("t5_cnt", 32'(stall_cnt), 1);
        tick();
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b1);
        checkVal("t5_stall_under_flush", 32'(stall_out), 1);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t5_cnt_flush", 32'(stall_cnt), 1);
        checkVal("t5_flushed_sel", 32'(fwd_sel), 0);
        tick();

        // 6. build stall_cnt up to 5, then reset asynchronously mid-stall
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd12, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t6_stall_pre", 32'(stall_out), 1);
        checkVal("t6_cnt_pre", 32'(stall_cnt), 5);
        #1;
        rst = 1'b1;
        #1;
        checkVal("t6_rst_stall", 32'(stall_out), 0);
        checkVal("t6_rst_sel", 32'(fwd_sel), 0);
        checkVal("t6_rst_cnt", 32'(stall_cnt), 0);
        rst = 1'b0;
        tick();
        drive(1'b1, 4'd12, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        checkVal("t6_post_sel", 32'(fwd_sel[1:0]), 0);
        checkVal("t6_post_stall", 32'(stall_out), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the in-order pipeline. It tracks in-flight register writes in an internal shift pipeline of STAGES entries. For each decode-stage source operand it selects the youngest matching producer stage or the register file. When a load result is not yet available, it stalls decode and inserts a bubble. A saturating stall-cycle counter is kept for performance monitoring.

Parameters:
AW, 4, register address width (2**AW architectural registers)
STAGES, 2, tracked in-flight stages ahead of decode (stage 0 = youngest, i.e. EX/MEM; stage 1 = MEM/WB)
NSRC, 2, source operands checked per decode instruction
LOAD_LAT, 1, load data is forwardable only from stage index >= LOAD_LAT
ZERO_REG_EN, 1, when 1, register 0 is never matched or forwarded
CNTW, 16, stall counter width
(derived) SELW = clog2(STAGES+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_src  in  NSRC*AW  source register addresses; operand i at bits [i*AW +: AW]
id_src_used  in  NSRC  operand i is actually read
id_rd  in  AW  destination register
id_regwrite  in  1  instruction writes id_rd
id_is_load  in  1  instruction is a load
flush  in  1  squash all in-flight entries
stall_out  out  1  hold decode/fetch this cycle
fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k+1 = forward from stage k
stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Entry k holds {valid, rd, is_load}. All storage is cleared asynchronously by rst. After reset: all entries invalid, stall_out=0, fwd_sel=0, stall_cnt=0.
- Match rule for entry k against operand i: entry.valid & id_valid & id_src_used[i] & (entry.rd == src_i) & !(ZERO_REG_EN & src_i == 0).
- Youngest wins: the lowest matching k determines the result for operand i.
- Hazard: if the youngest match for any operand i is a load with k < LOAD_LAT, stall_out=1 and every fwd_sel field is forced to 0 that cycle.
- Otherwise fwd_sel[i] = k+1 for the youngest match, or 0 if there is no match.
- stall_out and fwd_sel are combinational from current inputs and registered entries. There is no added latency.
- On each clk edge:
  - If flush=1: all entries become invalid. Flush overrides issue and stall.
  - Else: entries shift, entry k+1 <= entry k. The oldest entry is discarded.
  - Entry 0 <= {id_valid & id_regwrite & !stall_out, id_rd, id_is_load}. When stalled, a bubble (valid=0) is inserted.
- An instruction without regwrite occupies a bubble slot, so stage positions stay aligned with the pipeline.
- stall_cnt increments on each edge where stall_out=1 and flush=0. It saturates at 2**CNTW-1 and does not wrap.
- Reset mid-operation: entries are cleared immediately (asynchronously). The counter returns to 0. Outputs fall to 0 without waiting for a clock.
- STAGES=1 is legal (SELW=1). LOAD_LAT >= STAGES means a matching load always stalls until it leaves the tracked window. A stall only happens while the load is within the window.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF=0 constant
  - sel_width function (clog2(STAGES+1))
  - inflight_entry_t typedef {valid, rd, is_load}
- Sub-module fwd_match: one instance per operand. Each instance does a priority search over the STAGES entries and returns {hit, stage_index, is_load_hit}.
- The top level owns the shift pipeline, stall merge, fwd_sel forcing and stall_cnt.

Test Plan:
1. Defaults. Issue rd=12 (regwrite, non-load). Next cycle src0=12, src1=15, both used -> fwd_sel0=1, fwd_sel1=0, stall_out=0. Following cycle src1=12 -> fwd_sel1=2.
2. Two producers: issue rd=13, then rd=13 again. Next cycle src0=13 -> fwd_sel0=1 (youngest wins, not 2).
3. Load-use: issue load rd=12. Next cycle src0=12 -> stall_out=1, fwd_sel=0, stall_cnt=1 after the edge. Hold decode the next cycle -> stall_out=0, fwd_sel0=2.
4. Filters:
   - src=0 against entry rd=0 -> fwd_sel=0.
   - src=11 with id_src_used=0 against a load in stage 0 -> no stall.
   - regwrite=0 producer rd=12 -> no forward.
5. Flush: issue load rd=12, assert flush on the same edge. Next cycle src0=12 -> stall_out=0, fwd_sel0=0, stall_cnt unchanged.
6. Reset mid-stall: a load-use stall is active and stall_cnt=5. Assert rst between edges -> stall_out, fwd_sel and stall_cnt go to 0 immediately. After release, src0=12 -> fwd_sel0=0.
